// File: rtl/audio_ctrl_pkg.sv
// Shared types and defaults for the audio control-side blocks.
package audio_ctrl_pkg;

  typedef enum logic [1:0] {
    HOLD   = 2'd0,
    RAMP   = 2'd1,
    MUTING = 2'd2,
    MUTED  = 2'd3
  } gain_state_t;

  // 10 ms at 100 MHz
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 1000000;
  localparam int unsigned DEFAULT_RAMP_DIV        = 1;

  // Bits needed for a counter running 0..n-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchroniser followed by a stability counter. A new value is
// accepted only after it has differed from the stable value for COUNT
// consecutive cycles; any return to the stable value restarts the count.
module sync_debounce
  import audio_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned COUNT = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic             i_clk,
  input  logic             i_resetn,
  input  logic [WIDTH-1:0] i_raw,
  output logic [WIDTH-1:0] o_stable
);

  localparam int unsigned     CW       = cnt_width(COUNT);
  localparam logic [CW-1:0]   CNT_LAST = CW'(COUNT - 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_stable;
  logic [CW-1:0]    r_cnt;

  // Synchronise the raw input, then qualify changes by how long they persist.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_stable <= '0;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_ONE;
      end
    end
  end

  assign o_stable = r_stable;

endmodule

// File: rtl/axis_gain_sequencer.sv
// Turns debounced volume switches and a mute button into a gain code that
// moves one LSB per RAMP_DIV audio frames toward its goal. Frame ends are
// observed on passive taps of the datapath slave AXIS handshake.
module axis_gain_sequencer
  import audio_ctrl_pkg::*;
#(
  parameter int unsigned SWITCH_WIDTH    = 4,
  parameter int unsigned GAIN_WIDTH      = 8,
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned RAMP_DIV        = DEFAULT_RAMP_DIV
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [SWITCH_WIDTH-1:0] sw,
  input  logic                    mute_btn,
  input  logic                    frame_valid,
  input  logic                    frame_ready,
  input  logic                    frame_last,
  output logic [GAIN_WIDTH-1:0]   gain,
  output logic                    gain_update,
  output logic                    muted,
  output logic                    ramp_busy
);

  localparam int unsigned REPL = GAIN_WIDTH / SWITCH_WIDTH;
  localparam int unsigned DW   = (cnt_width(RAMP_DIV) < 2) ? 2 : cnt_width(RAMP_DIV);
  localparam logic [DW-1:0]         DIV_LAST = DW'(RAMP_DIV - 1);
  localparam logic [DW-1:0]         DIV_ONE  = DW'(1);
  localparam logic [GAIN_WIDTH-1:0] GAIN_ONE = GAIN_WIDTH'(1);

  logic [SWITCH_WIDTH-1:0] w_sw_stable;
  logic [0:0]              w_btn_stable;
  logic                    r_btn_prev;
  logic                    w_toggle;
  logic [GAIN_WIDTH-1:0]   w_target;

  logic                    w_frame_end;
  logic [DW-1:0]           r_div;
  logic                    w_step;

  gain_state_t             r_state;
  logic                    w_mute_cur;
  logic                    w_mute_next;
  logic [GAIN_WIDTH-1:0]   w_goal_cur;
  logic [GAIN_WIDTH-1:0]   w_goal_next;
  logic [GAIN_WIDTH-1:0]   w_gain_next;

  logic [GAIN_WIDTH-1:0]   r_gain;
  logic                    r_update;
  logic                    r_muted;
  logic                    r_busy;

  sync_debounce #(
    .WIDTH (SWITCH_WIDTH),
    .COUNT (DEBOUNCE_CYCLES)
  ) u_sw_db (
    .i_clk    (clk),
    .i_resetn (resetn),
    .i_raw    (sw),
    .o_stable (w_sw_stable)
  );

  sync_debounce #(
    .WIDTH (1),
    .COUNT (DEBOUNCE_CYCLES)
  ) u_btn_db (
    .i_clk    (clk),
    .i_resetn (resetn),
    .i_raw    (mute_btn),
    .o_stable (w_btn_stable)
  );

  assign w_target    = {REPL{w_sw_stable}};
  assign w_toggle    = w_btn_stable[0] & ~r_btn_prev;
  assign w_frame_end = frame_valid & frame_ready & frame_last;
  assign w_step      = w_frame_end && (r_div == DIV_LAST);

  // Count frame ends modulo RAMP_DIV; the wrapping frame end is the step event.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_div <= '0;
    end else if (w_frame_end) begin
      r_div <= (r_div == DIV_LAST) ? '0 : r_div + DIV_ONE;
    end
  end

  // Goal follows the mute side the FSM lands on this cycle, so a toggle
  // coinciding with a step already steers that step.
  always_comb begin
    w_mute_cur  = (r_state == MUTING) || (r_state == MUTED);
    w_mute_next = w_mute_cur ^ w_toggle;
    w_goal_cur  = w_mute_cur  ? '0 : w_target;
    w_goal_next = w_mute_next ? '0 : w_target;
    w_gain_next = r_gain;
    if (w_step) begin
      if (r_gain < w_goal_next) begin
        w_gain_next = r_gain + GAIN_ONE;
      end else if (r_gain > w_goal_next) begin
        w_gain_next = r_gain - GAIN_ONE;
      end
    end
  end

  // Gain register, sequencing FSM and registered status outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= HOLD;
      r_gain     <= '0;
      r_update   <= 1'b0;
      r_muted    <= 1'b0;
      r_busy     <= 1'b0;
      r_btn_prev <= 1'b0;
    end else begin
      r_btn_prev <= w_btn_stable[0];
      r_gain     <= w_gain_next;
      r_update   <= (w_gain_next != r_gain);
      r_busy     <= (r_gain != w_goal_cur);
      case (r_state)
        HOLD: begin
          if (w_toggle) begin
            r_state <= MUTING;
          end else if (w_gain_next != w_target) begin
            r_state <= RAMP;
          end
        end
        RAMP: begin
          if (w_toggle) begin
            r_state <= MUTING;
          end else if (w_gain_next == w_target) begin
            r_state <= HOLD;
          end
        end
        MUTING: begin
          if (w_toggle) begin
            r_state <= RAMP;
          end else if (w_gain_next == '0) begin
            r_state <= MUTED;
            r_muted <= 1'b1;
          end
        end
        MUTED: begin
          if (w_toggle) begin
            r_state <= RAMP;
            r_muted <= 1'b0;
          end
        end
        default: r_state <= HOLD;
      endcase
    end
  end

  assign gain        = r_gain;
  assign gain_update = r_update;
  assign muted       = r_muted;
  assign ramp_busy   = r_busy;

endmodule

// File: tb/tb_axis_gain_sequencer.sv
// Directed bench for axis_gain_sequencer: DEBOUNCE_CYCLES=4, two-word frames,
// one instance with RAMP_DIV=1 and a second sharing all inputs with RAMP_DIV=3.
module tb_axis_gain_sequencer;
  import audio_ctrl_pkg::*;

  logic       clk;
  logic       resetn;
  logic [3:0] sw;
  logic       mute_btn;
  logic       frame_valid;
  logic       frame_ready;
  logic       frame_last;
  logic [7:0] gain;
  logic       gain_update;
  logic       muted;
  logic       ramp_busy;
  logic [7:0] gain3;
  logic       gain_update3;
  logic       muted3;
  logic       ramp_busy3;

  int n_tests;
  int n_fail;
  int n_upd;

  axis_gain_sequencer #(
    .SWITCH_WIDTH    (4),
    .GAIN_WIDTH      (8),
    .DEBOUNCE_CYCLES (4),
    .RAMP_DIV        (1)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .sw          (sw),
    .mute_btn    (mute_btn),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_last  (frame_last),
    .gain        (gain),
    .gain_update (gain_update),
    .muted       (muted),
    .ramp_busy   (ramp_busy)
  );

  axis_gain_sequencer #(
    .SWITCH_WIDTH    (4),
    .GAIN_WIDTH      (8),
    .DEBOUNCE_CYCLES (4),
    .RAMP_DIV        (3)
  ) dut3 (
    .clk         (clk),
    .resetn      (resetn),
    .sw          (sw),
    .mute_btn    (mute_btn),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_last  (frame_last),
    .gain        (gain3),
    .gain_update (gain_update3),
    .muted       (muted3),
    .ramp_busy   (ramp_busy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count gain_update pulses of the RAMP_DIV=1 instance, sampled mid-cycle.
  always @(negedge clk) begin
    if (gain_update === 1'b1) n_upd++;
  end

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Two-word frame followed by one idle cycle.
  task automatic frames(input int unsigned n);
    repeat (n) begin
      frame_valid = 1'b1; frame_ready = 1'b1; frame_last = 1'b0;
      tick(1);
      frame_last = 1'b1;
      tick(1);
      frame_valid = 1'b0; frame_ready = 1'b0; frame_last = 1'b0;
      tick(1);
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic press_mute();
    mute_btn = 1'b1;
    tick(10);
    mute_btn = 1'b0;
    tick(10);
  endtask

  task automatic do_reset(input logic [3:0] sw_val);
    resetn = 1'b0;
    sw     = sw_val;
    tick(2);
    resetn = 1'b1;
  endtask

  initial begin
    n_tests = 0; n_fail = 0; n_upd = 0;
    resetn = 1'b0; sw = 4'h0; mute_btn = 1'b0;
    frame_valid = 1'b0; frame_ready = 1'b0; frame_last = 1'b0;

    // Reset values and full climb to unity with sw=F held through reset
    do_reset(4'hF);
    check("rst_gain", gain, 8'h00);
    check("rst_update", gain_update, 1'b0);
    check("rst_muted", muted, 1'b0);
    check("rst_busy", ramp_busy, 1'b0);
    check("rst_state", dut.r_state, HOLD);
    tick(10);
    n_upd = 0;
    frames(2);
    check("climb_2", gain, 8'h02);
    check("div3_2frames", gain3, 8'h00);
    frames(1);
    check("climb_3", gain, 8'h03);
    check("div3_3frames", gain3, 8'h01);
    frames(297);
    check("climb_gain", gain, 8'hFF);
    check("climb_updates", n_upd, 255);
    check("div3_300frames", gain3, 8'd100);
    tick(2);
    check("climb_busy", ramp_busy, 1'b0);
    check("climb_state", dut.r_state, HOLD);

    // Short switch glitch must be rejected
    do_reset(4'h0);
    tick(10);
    n_upd = 0;
    sw = 4'h8;
    tick(3);
    sw = 4'h0;
    tick(10);
    frames(5);
    check("glitch_gain", gain, 8'h00);
    check("glitch_updates", n_upd, 0);

    // Mute from 0x88, then unmute back
    sw = 4'h8;
    tick(10);
    frames(136);
    check("pre_mute_gain", gain, 8'h88);
    n_upd = 0;
    press_mute();
    check("muting_gain_hold", gain, 8'h88);
    check("muting_state", dut.r_state, MUTING);
    frames(135);
    check("muting_gain1", gain, 8'h01);
    check("muting_not_muted", muted, 1'b0);
    frames(1);
    check("muted_gain", gain, 8'h00);
    check("muted_flag", muted, 1'b1);
    check("mute_updates", n_upd, 136);
    press_mute();
    check("unmute_flag", muted, 1'b0);
    frames(1);
    check("unmute_gain1", gain, 8'h01);
    check("unmute_busy", ramp_busy, 1'b1);
    frames(135);
    tick(2);
    check("unmute_gain", gain, 8'h88);
    check("unmute_busy_end", ramp_busy, 1'b0);
    check("unmute_state", dut.r_state, HOLD);

    // Target reversal mid-ramp
    do_reset(4'h4);
    tick(10);
    frames(64);
    check("rev_start", gain, 8'h40);
    sw = 4'h2;
    tick(10);
    check("rev_no_step", gain, 8'h40);
    frames(1);
    check("rev_first", gain, 8'h3F);
    frames(29);
    check("rev_end", gain, 8'h22);
    frames(3);
    check("rev_settled", gain, 8'h22);

    // Handshake variants that must not step
    sw = 4'h3;
    tick(10);
    frame_valid = 1'b1; frame_last = 1'b1; frame_ready = 1'b0;
    tick(1);
    frame_valid = 1'b0; frame_last = 1'b0;
    tick(1);
    check("no_ready_gain", gain, 8'h22);
    check("no_ready_update", gain_update, 1'b0);
    frame_valid = 1'b1; frame_ready = 1'b1; frame_last = 1'b0;
    tick(3);
    frame_valid = 1'b0; frame_ready = 1'b0;
    tick(1);
    check("no_last_gain", gain, 8'h22);
    frames(1);
    check("hs_step", gain, 8'h23);

    // Asynchronous reset mid-ramp, then soft start
    do_reset(4'h5);
    tick(10);
    frames(80);
    check("pre_rst_gain", gain, 8'h50);
    check("pre_rst_busy", ramp_busy, 1'b1);
    #3 resetn = 1'b0;
    #1;
    check("async_rst_gain", gain, 8'h00);
    check("async_rst_gain3", gain3, 8'h00);
    check("async_rst_busy", ramp_busy, 1'b0);
    tick(1);
    resetn = 1'b1;
    tick(10);
    frames(1);
    check("soft_start", gain, 8'h01);
    frames(84);
    tick(2);
    check("soft_end", gain, 8'h55);
    check("soft_busy", ramp_busy, 1'b0);
    check("soft_state", dut.r_state, HOLD);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
